// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder. Oversamples the host SPI clock, decodes
// 48-bit command frames, answers with R1 and, for CMD17, streams a data
// block read from an external byte memory.
module sd_spi_responder #(
   parameter int BLOCK_SIZE = 16,
   parameter int NCR_BYTES  = 1,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss,
   output logic              miso,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              cmd_valid,
   output logic [5:0]        cmd_index,
   output logic [31:0]       cmd_arg,
   output logic              crc_err
);

   localparam int BYTE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int NCR_W  = (NCR_BYTES > 1) ? $clog2(NCR_BYTES) : 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BLOCK_SIZE - 1);
   localparam logic [NCR_W-1:0]  LAST_NCR  = NCR_W'(NCR_BYTES - 1);

   typedef enum logic [2:0] {
      S_HUNT, S_CMD, S_NCR, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC
   } state_t;

   state_t            state;
   logic [2:0]        sclk_q;     // [1:0] synchronizer, [2] previous sample
   logic [1:0]        mosi_q;
   logic [1:0]        ss_q;
   logic [46:0]       rx_sr;
   logic [5:0]        rx_cnt;
   logic [6:0]        crc;
   logic [7:0]        tx_sr;
   logic [7:0]        r1;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] byte_cnt;
   logic [NCR_W-1:0]  ncr_cnt;
   logic              data_pend;
   logic              idle;
   logic              app;

   // NOTE: plain continuous assigns for the combinational helpers leave no
   // path that could hold a value, so nothing here can become a latch.
   logic        sclk_rise, sclk_fall, mosi_s, ss_s, crc_fb;
   logic [47:0] frame;
   logic [6:0]  crc_nxt;
   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign mosi_s    = mosi_q[1];
   assign ss_s      = ss_q[1];
   assign frame     = {rx_sr, mosi_s};
   assign crc_fb    = mosi_s ^ crc[6];
   assign crc_nxt   = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);

   // Two-flop synchronizers for the host pins plus the sclk edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q <= '0;
         mosi_q <= '1;
         ss_q   <= '1;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         mosi_q <= {mosi_q[0], mosi};
         ss_q   <= {ss_q[0], ss};
      end
   end

   // Command receive, response/data transmit and card flags.
   // NOTE: non-blocking assignments so every register reads pre-edge values;
   // later assignments in the same edge deliberately override earlier ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_HUNT;
         miso      <= 1'b1;
         rd_addr   <= '0;
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         cmd_index <= '0;
         cmd_arg   <= '0;
         idle      <= 1'b1;
         app       <= 1'b0;
         rx_sr     <= '0;
         rx_cnt    <= '0;
         crc       <= '0;
         tx_sr     <= 8'hFF;
         r1        <= 8'hFF;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         ncr_cnt   <= '0;
         data_pend <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         if (ss_s) begin
            // Deselected: abandon any frame or response, keep the card flags.
            state    <= S_HUNT;
            miso     <= 1'b1;
            rx_cnt   <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ncr_cnt  <= '0;
         end else begin
            case (state)
               S_HUNT, S_CMD: begin
                  if (sclk_fall) miso <= 1'b1;
                  if (sclk_rise) begin
                     rx_sr <= {rx_sr[45:0], mosi_s};
                     if (state == S_HUNT) begin
                        if (!mosi_s) begin
                           // The start bit is 0, so it leaves the CRC at 0.
                           state  <= S_CMD;
                           rx_cnt <= 6'd1;
                           crc    <= 7'h00;
                        end
                     end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt < 6'd40) crc <= crc_nxt;
                        if (rx_cnt == 6'd47) begin
                           state <= S_HUNT;
                           if (!frame[47] && frame[46] && frame[0]) begin
                              state     <= S_NCR;
                              tx_sr     <= 8'hFF;
                              bit_cnt   <= '0;
                              ncr_cnt   <= '0;
                              data_pend <= 1'b0;
                              if (crc != frame[7:1]) begin
                                 r1      <= {4'b0000, 1'b1, 2'b00, idle};
                                 crc_err <= 1'b1;
                              end else begin
                                 cmd_valid <= 1'b1;
                                 cmd_index <= frame[45:40];
                                 cmd_arg   <= frame[39:8];
                                 app       <= 1'b0;
                                 case (frame[45:40])
                                    6'd0: begin
                                       idle <= 1'b1;
                                       r1   <= 8'h01;
                                    end
                                    6'd55: begin
                                       app <= 1'b1;
                                       r1  <= {7'b0, idle};
                                    end
                                    6'd41: begin
                                       if (app) begin
                                          idle <= 1'b0;
                                          r1   <= 8'h00;
                                       end else begin
                                          r1 <= {5'b0, 1'b1, 1'b0, idle};
                                       end
                                    end
                                    6'd17: begin
                                       if (!idle) begin
                                          r1        <= 8'h00;
                                          data_pend <= 1'b1;
                                       end else begin
                                          r1 <= 8'h05;
                                       end
                                    end
                                    default: r1 <= {5'b0, 1'b1, 1'b0, idle};
                                 endcase
                              end
                           end
                        end
                     end
                  end
               end
               default: begin
                  if (sclk_fall) begin
                     miso    <= tx_sr[7];
                     tx_sr   <= {tx_sr[6:0], 1'b1};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 3'd7) begin
                        // Last bit of a byte goes out now; queue the next byte.
                        case (state)
                           S_NCR: begin
                              if (ncr_cnt == LAST_NCR) begin
                                 state <= S_R1;
                                 tx_sr <= r1;
                              end else begin
                                 ncr_cnt <= ncr_cnt + 1'b1;
                                 tx_sr   <= 8'hFF;
                              end
                           end
                           S_R1: begin
                              if (data_pend) begin
                                 state   <= S_GAP;
                                 tx_sr   <= 8'hFF;
                                 rd_addr <= cmd_arg[ADDR_W-1:0];
                              end else begin
                                 state <= S_HUNT;
                              end
                           end
                           S_GAP: begin
                              state <= S_TOKEN;
                              tx_sr <= 8'hFE;
                           end
                           S_TOKEN: begin
                              state    <= S_DATA;
                              tx_sr    <= rd_data;
                              byte_cnt <= '0;
                              if (BLOCK_SIZE > 1) rd_addr <= rd_addr + 1'b1;
                           end
                           S_DATA: begin
                              if (byte_cnt == LAST_BYTE) begin
                                 state    <= S_CRC;
                                 tx_sr    <= 8'hFF;
                                 byte_cnt <= '0;
                              end else begin
                                 tx_sr    <= rd_data;
                                 byte_cnt <= byte_cnt + 1'b1;
                                 // Stop advancing once the final byte is addressed.
                                 if (byte_cnt + 1'b1 != LAST_BYTE) rd_addr <= rd_addr + 1'b1;
                              end
                           end
                           S_CRC: begin
                              tx_sr <= 8'hFF;
                              if (byte_cnt == BYTE_W'(1)) state <= S_HUNT;
                              else byte_cnt <= byte_cnt + 1'b1;
                           end
                           default: state <= S_HUNT;
                        endcase
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI mode-0 host, byte memory model
// returning address + 0x10, and immediate-assertion checks.
`timescale 1ns/1ps
module tb_sd_spi_responder;

   localparam int BS   = 4;
   localparam int HALF = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk;
   logic        mosi;
   logic        ss;
   logic        miso;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        crc_err;

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0;
   int ce_cnt = 0;
   int cv0, ce0;
   logic [7:0] addr_log[$];
   logic [7:0] last_addr = 8'h00;
   logic [7:0] b;
   logic [47:0] part;
   logic [7:0] exp17 [10] = '{8'hFF, 8'h00, 8'hFF, 8'hFE, 8'h13,
                              8'h14, 8'h15, 8'h16, 8'hFF, 8'hFF};

   sd_spi_responder #(.BLOCK_SIZE(BS), .NCR_BYTES(1), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .cmd_valid (cmd_valid),
      .cmd_index (cmd_index),
      .cmd_arg   (cmd_arg),
      .crc_err   (crc_err)
   );

   always #5 clk = ~clk;

   // Block memory: byte a holds a + 0x10, one clk read latency.
   always @(posedge clk) rd_data <= rd_addr + 8'h10;

   // Pulse counters and rd_addr history, sampled mid-cycle.
   always @(negedge clk) begin
      if (cmd_valid === 1'b1) cv_cnt++;
      if (crc_err === 1'b1) ce_cnt++;
      if (rd_addr !== last_addr) begin
         addr_log.push_back(rd_addr);
         last_addr = rd_addr;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] crc_byte(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return {c, 1'b1};
   endfunction

   task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #HALF;
         rx[i] = miso;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic send_raw(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc8);
      logic [47:0] f;
      logic [7:0]  dummy;
      f = {2'b01, idx, arg, crc8};
      for (int k = 5; k >= 0; k--) xfer_byte(f[k*8 +: 8], dummy);
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
      send_raw(idx, arg, crc_byte({2'b01, idx, arg}));
   endtask

   // Send a command and check the NCR filler and R1 byte that follow.
   task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] exp_r1);
      logic [7:0] r;
      send_cmd(idx, arg);
      xfer_byte(8'hFF, r);
      check({tag, " ncr"}, {24'h0, r}, 32'hFF);
      xfer_byte(8'hFF, r);
      check({tag, " r1"}, {24'h0, r}, {24'h0, exp_r1});
   endtask

   initial begin
      rst  = 1'b1;
      sclk = 1'b0;
      mosi = 1'b1;
      ss   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset miso", {31'h0, miso}, 32'h1);
      check("reset rd_addr", {24'h0, rd_addr}, 32'h0);
      check("reset cmd_valid", {31'h0, cmd_valid}, 32'h0);
      check("reset crc_err", {31'h0, crc_err}, 32'h0);
      check("reset cmd_index", {26'h0, cmd_index}, 32'h0);
      check("reset cmd_arg", cmd_arg, 32'h0);
      rst = 1'b0;
      ss  = 1'b0;
      repeat (4) @(negedge clk);

      // CMD0 with its well-known CRC byte.
      cv0 = cv_cnt; ce0 = ce_cnt;
      send_raw(6'd0, 32'h0, 8'h95);
      xfer_byte(8'hFF, b); check("cmd0 ncr", {24'h0, b}, 32'hFF);
      xfer_byte(8'hFF, b); check("cmd0 r1", {24'h0, b}, 32'h01);
      check("cmd0 cmd_valid pulses", cv_cnt - cv0, 1);
      check("cmd0 crc_err pulses", ce_cnt - ce0, 0);
      check("cmd0 cmd_index", {26'h0, cmd_index}, 32'd0);
      check("cmd0 cmd_arg", cmd_arg, 32'h0);

      // CMD0 with a corrupted CRC byte.
      cv0 = cv_cnt; ce0 = ce_cnt;
      send_raw(6'd0, 32'h0, 8'h97);
      xfer_byte(8'hFF, b); check("badcrc ncr", {24'h0, b}, 32'hFF);
      xfer_byte(8'hFF, b); check("badcrc r1", {24'h0, b}, 32'h09);
      check("badcrc crc_err pulses", ce_cnt - ce0, 1);
      check("badcrc cmd_valid pulses", cv_cnt - cv0, 0);

      // Initialisation, then back to idle.
      cmd_r1("cmd55", 6'd55, 32'h0, 8'h01);
      cmd_r1("acmd41", 6'd41, 32'h0, 8'h00);
      check("acmd41 cmd_index", {26'h0, cmd_index}, 32'd41);
      cmd_r1("cmd0 again", 6'd0, 32'h0, 8'h01);

      // Initialise and read block at address 3.
      cmd_r1("init cmd55", 6'd55, 32'h0, 8'h01);
      cmd_r1("init acmd41", 6'd41, 32'h0, 8'h00);
      addr_log.delete();
      send_cmd(6'd17, 32'h3);
      for (int i = 0; i < 10; i++) begin
         xfer_byte(8'hFF, b);
         check($sformatf("cmd17 byte %0d", i), {24'h0, b}, {24'h0, exp17[i]});
      end
      check("cmd17 addr steps", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         check($sformatf("cmd17 rd_addr %0d", i), {24'h0, addr_log[i]}, 32'd3 + i);
      check("cmd17 cmd_index", {26'h0, cmd_index}, 32'd17);
      check("cmd17 cmd_arg", cmd_arg, 32'h3);

      // Unsupported command after init.
      cmd_r1("cmd9", 6'd9, 32'h0, 8'h04);
      check("cmd9 cmd_index", {26'h0, cmd_index}, 32'd9);

      // CMD17 while idle: no data phase.
      cmd_r1("idle cmd0", 6'd0, 32'h0, 8'h01);
      cmd_r1("idle cmd17", 6'd17, 32'h0, 8'h05);
      xfer_byte(8'hFF, b); check("idle cmd17 tail0", {24'h0, b}, 32'hFF);
      xfer_byte(8'hFF, b); check("idle cmd17 tail1", {24'h0, b}, 32'hFF);
      check("idle cmd17 rd_addr quiet", addr_log.size(), 4);

      // Partial frame abandoned by ss, then a full CMD0.
      cmd_r1("part cmd55", 6'd55, 32'h0, 8'h01);
      cmd_r1("part acmd41", 6'd41, 32'h0, 8'h00);
      part = {2'b01, 6'd9, 32'h0, 8'hAF};
      for (int i = 47; i > 27; i--) begin
         mosi = part[i];
         #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
      end
      ss = 1'b1;
      repeat (6) @(negedge clk);
      check("ss high miso", {31'h0, miso}, 32'h1);
      cv0 = cv_cnt;
      xfer_byte(8'h00, b);
      xfer_byte(8'h00, b);
      check("ss high miso idle", {24'h0, b}, 32'hFF);
      ss = 1'b0;
      repeat (4) @(negedge clk);
      cmd_r1("after ss cmd0", 6'd0, 32'h0, 8'h01);
      check("after ss cmd_valid pulses", cv_cnt - cv0, 1);

      // Reset in the middle of the data phase.
      cmd_r1("rst cmd55", 6'd55, 32'h0, 8'h01);
      cmd_r1("rst acmd41", 6'd41, 32'h0, 8'h00);
      send_cmd(6'd17, 32'h3);
      for (int i = 0; i < 4; i++) begin
         xfer_byte(8'hFF, b);
         check($sformatf("rst cmd17 byte %0d", i), {24'h0, b}, {24'h0, exp17[i]});
      end
      for (int i = 0; i < 2; i++) begin
         mosi = 1'b1;
         #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
      end
      #HALF;
      check("data bit before reset", {31'h0, miso}, 32'h0);
      rst = 1'b1;
      #1;
      check("mid reset miso", {31'h0, miso}, 32'h1);
      check("mid reset rd_addr", {24'h0, rd_addr}, 32'h0);
      check("mid reset cmd_valid", {31'h0, cmd_valid}, 32'h0);
      check("mid reset crc_err", {31'h0, crc_err}, 32'h0);
      check("mid reset cmd_index", {26'h0, cmd_index}, 32'h0);
      check("mid reset cmd_arg", cmd_arg, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      cmd_r1("post reset cmd17", 6'd17, 32'h3, 8'h05);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
